// File: rtl/dnn_layer_sequencer_pkg.sv
// rtl/dnn_layer_sequencer_pkg.sv - shared states, defaults and weight ROM layer bases
package dnn_seq_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SELECT = 3'd1,
        LAUNCH = 3'd2,
        RUN    = 3'd3,
        DONE   = 3'd4,
        ERROR  = 3'd5
    } seq_state_t;

    localparam int MAX_LAYERS     = 8;
    localparam int DEF_NUM_LAYERS = 3;
    localparam int DEF_N_IN       = 64;
    localparam int DEF_LADDR_W    = 12;
    localparam int DEF_ROM_ADDR_W = 12;
    localparam int ROM_DEPTH      = 4096;
    localparam int DEF_TIMEOUT    = 4095;
    localparam int BASE_W         = 16;

    // Weights plus bias packed back to back: 64x32+32, 32x16+16, 16x10+10.
    // Slots beyond the third layer point at the first free word.
    localparam logic [MAX_LAYERS-1:0][BASE_W-1:0] LAYER_BASE = {
        16'd2778, 16'd2778, 16'd2778, 16'd2778, 16'd2778,
        16'd2608, 16'd2080, 16'd0
    };

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dnn_layer_sequencer_if.sv
// rtl/dnn_layer_sequencer_if.sv - host frame-in / result-out handshake bundle
interface dnn_layer_sequencer_if #(
    parameter int N_IN = 64
);
    logic            in_valid;
    logic            in_ready;
    logic [N_IN-1:0] in_data;
    logic            out_valid;
    logic            out_ready;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid
    );
endinterface

// File: rtl/dnn_layer_sequencer_rom_addr_mux.sv
// rtl/dnn_layer_sequencer_rom_addr_mux.sv - selects active layer address and offsets it by its ROM base
module dnn_rom_addr_mux #(
    parameter int NUM_LAYERS = 3,
    parameter int LADDR_W    = 12,
    parameter int ROM_ADDR_W = 12,
    parameter int SEL_W      = 2
) (
    input  logic [SEL_W-1:0]                       sel,
    input  logic [NUM_LAYERS-1:0][LADDR_W-1:0]     layer_addr,
    input  logic [NUM_LAYERS-1:0][ROM_ADDR_W-1:0]  bases,
    output logic [ROM_ADDR_W-1:0]                  rom_addr
);

    // Loop mux so an out-of-range sel reads address zero instead of indexing past the array.
    always_comb begin
        rom_addr = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            if (sel == SEL_W'(i)) begin
                rom_addr = bases[i] + ROM_ADDR_W'(layer_addr[i]);
            end
        end
    end

endmodule

// File: rtl/dnn_layer_sequencer.sv
// rtl/dnn_layer_sequencer.sv - dense layer chain sequencer top; DNN_SEQ_PERF_EN adds perf_cycles counter
module dnn_layer_sequencer
    import dnn_seq_pkg::*;
#(
    parameter int NUM_LAYERS = DEF_NUM_LAYERS,
    parameter int N_IN       = DEF_N_IN,
    parameter int LADDR_W    = DEF_LADDR_W,
    parameter int ROM_ADDR_W = DEF_ROM_ADDR_W,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                               clk,
    input  logic                               rst_n,
    dnn_layer_sequencer_if.slave               host,
    output logic [N_IN-1:0]                    frame_out,
    output logic [NUM_LAYERS-1:0]              layer_start,
    input  logic [NUM_LAYERS-1:0]              layer_finish,
    input  logic [NUM_LAYERS-1:0][LADDR_W-1:0] layer_addr,
    output logic [ROM_ADDR_W-1:0]              rom_addr,
    output logic                               busy,
    output logic                               error
`ifdef DNN_SEQ_PERF_EN
    ,
    output logic [31:0]                        perf_cycles
`endif
);

    localparam int SEL_W  = sel_width(NUM_LAYERS);
    localparam int WDOG_W = $clog2(TIMEOUT + 1);

    seq_state_t                           state;
    seq_state_t                           next_state;
    logic [SEL_W-1:0]                     sel;
    logic [WDOG_W-1:0]                    wdog;
    logic                                 accept;
    logic                                 fin_sel;
    logic                                 last_sel;
    logic                                 wdog_expired;
    logic                                 in_ready_c;
    logic                                 out_valid_c;
    logic                                 busy_c;
    logic                                 error_c;
    logic [NUM_LAYERS-1:0]                start_c;
    logic [NUM_LAYERS-1:0][ROM_ADDR_W-1:0] bases;

    for (genvar g = 0; g < NUM_LAYERS; g++) begin : g_base
        assign bases[g] = ROM_ADDR_W'(LAYER_BASE[g]);
    end

    assign accept       = (state == IDLE) && host.in_valid;
    assign last_sel     = (sel == SEL_W'(NUM_LAYERS - 1));
    assign wdog_expired = (wdog == WDOG_W'(TIMEOUT));

    // Finish of the currently selected layer only; other layers' pulses are ignored.
    always_comb begin
        fin_sel = 1'b0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            if (sel == SEL_W'(i)) begin
                fin_sel = layer_finish[i];
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and decoded outputs; a finish in the same cycle as expiry still advances.
    always_comb begin
        next_state  = state;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        busy_c      = 1'b1;
        error_c     = 1'b0;
        start_c     = '0;
        case (state)
            IDLE: begin
                in_ready_c = 1'b1;
                busy_c     = 1'b0;
                if (host.in_valid) begin
                    next_state = SELECT;
                end
            end
            SELECT: begin
                next_state = LAUNCH;
            end
            LAUNCH: begin
                // Suppressed while reset is asserted so no start escapes in that cycle.
                if (rst_n) begin
                    start_c = NUM_LAYERS'(1) << sel;
                end
                next_state = RUN;
            end
            RUN: begin
                if (fin_sel) begin
                    next_state = last_sel ? DONE : SELECT;
                end else if (wdog_expired) begin
                    next_state = ERROR;
                end
            end
            DONE: begin
                out_valid_c = 1'b1;
                if (host.out_ready) begin
                    next_state = IDLE;
                end
            end
            ERROR: begin
                error_c = 1'b1;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign host.in_ready  = in_ready_c;
    assign host.out_valid = out_valid_c;
    assign busy           = busy_c;
    assign error          = error_c;
    assign layer_start    = start_c;

    // Layer select: cleared while idle, stepped on each non-final finish so it changes on SELECT entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel <= '0;
        end else begin
            case (state)
                IDLE: sel <= '0;
                RUN: begin
                    if (fin_sel && !last_sel) begin
                        sel <= sel + SEL_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Per-layer watchdog: zeroed at launch, counts every RUN cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wdog <= '0;
        end else if (state == LAUNCH) begin
            wdog <= '0;
        end else if (state == RUN) begin
            wdog <= wdog + WDOG_W'(1);
        end
    end

    // Input frame captured on accept and held for the whole chain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_out <= '0;
        end else if (accept) begin
            frame_out <= host.in_data;
        end
    end

    dnn_rom_addr_mux #(
        .NUM_LAYERS (NUM_LAYERS),
        .LADDR_W    (LADDR_W),
        .ROM_ADDR_W (ROM_ADDR_W),
        .SEL_W      (SEL_W)
    ) u_rom_addr_mux (
        .sel        (sel),
        .layer_addr (layer_addr),
        .bases      (bases),
        .rom_addr   (rom_addr)
    );

`ifdef DNN_SEQ_PERF_EN
    // Cycles from accept until DONE entry; frozen in DONE, restarted on the next accept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_cycles <= '0;
        end else if (accept) begin
            perf_cycles <= '0;
        end else if (state == SELECT || state == LAUNCH || state == RUN) begin
            perf_cycles <= perf_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dnn_layer_sequencer.sv
// tb/tb_dnn_layer_sequencer.sv - directed self-checking bench for dnn_layer_sequencer
module tb_dnn_layer_sequencer;

    localparam int NL         = 3;
    localparam int N_IN       = 64;
    localparam int LADDR_W    = 12;
    localparam int ROM_ADDR_W = 12;
    localparam int TIMEOUT    = 4095;

    // Hand-computed ROM addresses at each layer start: base + local address.
    localparam int EXP_ADDR0 = 0 + 17;
    localparam int EXP_ADDR1 = 2080 + 33;
    localparam int EXP_ADDR2 = 2608 + 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dnn_layer_sequencer_if #(.N_IN(N_IN)) host_if();

    logic [N_IN-1:0]                frame_out;
    logic [NL-1:0]                  layer_start;
    logic [NL-1:0]                  layer_finish;
    logic [NL-1:0]                  model_fin;
    logic [NL-1:0]                  stray_mask;
    logic [NL-1:0][LADDR_W-1:0]     layer_addr;
    logic [ROM_ADDR_W-1:0]          rom_addr;
    logic                           busy;
    logic                           error;
`ifdef DNN_SEQ_PERF_EN
    logic [31:0]                    perf_cycles;
`endif

    assign layer_finish  = model_fin | stray_mask;
    assign layer_addr[0] = 12'd17;
    assign layer_addr[1] = 12'd33;
    assign layer_addr[2] = 12'd5;

    dnn_layer_sequencer #(
        .NUM_LAYERS (NL),
        .N_IN       (N_IN),
        .LADDR_W    (LADDR_W),
        .ROM_ADDR_W (ROM_ADDR_W),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .host         (host_if),
        .frame_out    (frame_out),
        .layer_start  (layer_start),
        .layer_finish (layer_finish),
        .layer_addr   (layer_addr),
        .rom_addr     (rom_addr),
        .busy         (busy),
        .error        (error)
`ifdef DNN_SEQ_PERF_EN
        ,
        .perf_cycles  (perf_cycles)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;
    int dly [NL];
    int cnt [NL];
    bit active [NL];
    bit found;
    int bad;
    int exp_addr [NL];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Layer models: finish pulses in the dly-th cycle after the start cycle; dly 0 never finishes.
    initial begin
        logic [NL-1:0] samp;
        bit rs;
        model_fin = '0;
        for (int i = 0; i < NL; i++) begin
            active[i] = 1'b0;
            cnt[i]    = 0;
        end
        forever begin
            @(negedge clk);
            samp = layer_start;
            @(posedge clk);
            rs = rst_n;
            #1;
            model_fin = '0;
            for (int i = 0; i < NL; i++) begin
                if (!rs) begin
                    active[i] = 1'b0;
                    cnt[i]    = 0;
                end else begin
                    if (active[i]) cnt[i]++;
                    if (samp[i]) begin
                        active[i] = 1'b1;
                        cnt[i]    = 1;
                    end
                    if (active[i] && cnt[i] == dly[i]) begin
                        model_fin[i] = 1'b1;
                        active[i]    = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation exceeded its time budget");
        $fatal(1, "global timeout");
    end

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic send_frame(input logic [63:0] data);
        @(negedge clk);
        host_if.in_valid = 1'b1;
        host_if.in_data  = data;
        @(posedge clk);
        #1 host_if.in_valid = 1'b0;
    endtask

    task automatic wait_for_start(input int idx, input int bound);
        found = 1'b0;
        for (int i = 0; i < bound && !found; i++) begin
            @(negedge clk);
            if (layer_start[idx]) found = 1'b1;
        end
        check_eq($sformatf("start%0d_seen", idx), 64'(found), 64'd1);
    endtask

    // Runs one frame to DONE, checking start order, start cycle, ROM address and latency.
    task automatic run_frame(input logic [63:0] data, input int stray_at, input int exp_lat);
        int k;
        int ns;
        int exp_k;
        send_frame(data);
        k     = 0;
        ns    = 0;
        exp_k = 2;
        while (k < exp_lat + 50) begin
            @(negedge clk);
            k++;
            stray_mask = (stray_at != 0 && k == stray_at) ? 3'b100 : 3'b000;
            if (stray_at != 0 && k == stray_at + 1) begin
                check_eq("stray_sel_kept", 64'(rom_addr), 64'(EXP_ADDR0));
            end
            if (k == 3) begin
                check_eq("run_busy", 64'(busy), 64'd1);
                check_eq("run_in_ready", 64'(host_if.in_ready), 64'd0);
                check_eq("run_frame_out", frame_out, data);
            end
            if (layer_start != '0) begin
                if (ns < NL) begin
                    check_eq("start_onehot", 64'(layer_start), 64'(1 << ns));
                    check_eq("start_cycle", 64'(k), 64'(exp_k));
                    check_eq("start_rom_addr", 64'(rom_addr), 64'(exp_addr[ns]));
                    exp_k += 2 + dly[ns];
                    ns++;
                end else begin
                    check_eq("extra_start", 64'(layer_start), 64'd0);
                end
            end
            if (host_if.out_valid) break;
        end
        stray_mask = '0;
        check_eq("latency", 64'(k), 64'(exp_lat));
        check_eq("start_count", 64'(ns), 64'(NL));
    endtask

    initial begin
        host_if.in_valid  = 1'b0;
        host_if.in_data   = '0;
        host_if.out_ready = 1'b0;
        stray_mask        = '0;
        exp_addr          = '{EXP_ADDR0, EXP_ADDR1, EXP_ADDR2};
        dly               = '{2114, 562, 180};

        // Reset values
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_in_ready", 64'(host_if.in_ready), 64'd1);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_out_valid", 64'(host_if.out_valid), 64'd0);
        check_eq("rst_error", 64'(error), 64'd0);
        check_eq("rst_layer_start", 64'(layer_start), 64'd0);
        check_eq("rst_frame_out", frame_out, 64'd0);

        // Full frame, stray finish[2] while layer 0 runs; latency 2116+564+182+1
        run_frame(64'hF0F0_0F0F_AAAA_5555, 100, 2863);
        check_eq("done_frame_out", frame_out, 64'hF0F0_0F0F_AAAA_5555);
`ifdef DNN_SEQ_PERF_EN
        check_eq("perf_full", 64'(perf_cycles), 64'd2862);
`endif

        // Backpressure in DONE with a competing frame offered
        host_if.in_valid = 1'b1;
        host_if.in_data  = 64'h1234_5678_9ABC_DEF0;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (!host_if.out_valid || host_if.in_ready || layer_start != '0 || !busy) bad++;
        end
        check_eq("bp_hold", 64'(bad), 64'd0);
        check_eq("bp_frame_stable", frame_out, 64'hF0F0_0F0F_AAAA_5555);
        host_if.in_valid  = 1'b0;
        host_if.out_ready = 1'b1;
        @(negedge clk);
        host_if.out_ready = 1'b0;
        check_eq("hs_out_valid", 64'(host_if.out_valid), 64'd0);
        check_eq("hs_in_ready", 64'(host_if.in_ready), 64'd1);
        check_eq("hs_busy", 64'(busy), 64'd0);
        check_eq("hs_frame_kept", frame_out, 64'hF0F0_0F0F_AAAA_5555);

        // Watchdog: layer 1 never finishes
        dly = '{20, 0, 180};
        send_frame(64'h0000_0000_0000_00FF);
        wait_for_start(1, 100);
        repeat (TIMEOUT + 1) @(negedge clk);
        check_eq("wdog_not_yet", 64'(error), 64'd0);
        @(negedge clk);
        check_eq("wdog_error", 64'(error), 64'd1);
        check_eq("wdog_busy", 64'(busy), 64'd1);
        check_eq("wdog_in_ready", 64'(host_if.in_ready), 64'd0);
        host_if.in_valid = 1'b1;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (!error || host_if.in_ready || layer_start != '0) bad++;
        end
        host_if.in_valid = 1'b0;
        check_eq("wdog_sticky", 64'(bad), 64'd0);
        do_reset();
        @(negedge clk);
        check_eq("wdog_cleared", 64'(error), 64'd0);
        check_eq("wdog_idle", 64'(busy), 64'd0);

        // Reset during the layer 1 start cycle: pulse suppressed
        dly = '{5, 562, 180};
        send_frame(64'h0F0F_0F0F_0F0F_0F0F);
        wait_for_start(1, 50);
        rst_n = 1'b0;
        #1;
        check_eq("rst_launch_start", 64'(layer_start), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_launch_idle", 64'(host_if.in_ready), 64'd1);
        check_eq("rst_launch_busy", 64'(busy), 64'd0);

        // Reset during layer 1 RUN
        send_frame(64'h5555_5555_AAAA_AAAA);
        wait_for_start(1, 50);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("rst_run_in_ready", 64'(host_if.in_ready), 64'd1);
        check_eq("rst_run_busy", 64'(busy), 64'd0);
        check_eq("rst_run_start", 64'(layer_start), 64'd0);
        check_eq("rst_run_frame", frame_out, 64'd0);
        check_eq("rst_run_out_valid", 64'(host_if.out_valid), 64'd0);
`ifdef DNN_SEQ_PERF_EN
        check_eq("rst_run_perf", 64'(perf_cycles), 64'd0);
`endif
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Recovery frame with short layers: latency 7+9+11+1
        dly = '{5, 7, 9};
        run_frame(64'hDEAD_BEEF_0123_4567, 0, 28);
        check_eq("rec_frame_out", frame_out, 64'hDEAD_BEEF_0123_4567);
`ifdef DNN_SEQ_PERF_EN
        check_eq("perf_short", 64'(perf_cycles), 64'd27);
`endif
        host_if.out_ready = 1'b1;
        @(negedge clk);
        host_if.out_ready = 1'b0;
        check_eq("rec_out_valid", 64'(host_if.out_valid), 64'd0);
        check_eq("rec_in_ready", 64'(host_if.in_ready), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
